// File: rtl/seg7_rx_decoder_if.sv
// seg7_rx_decoder_if: segment input, clear and symbol-stream handshake of the 7-segment receiver
interface seg7_rx_decoder_if;
   logic [6:0] seg_in;
   logic       clr;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_sym;
   logic       overflow;
   logic [7:0] err_cnt;
   modport master (output seg_in, clr, out_ready, input out_valid, out_sym, overflow, err_cnt);
   modport slave (input seg_in, clr, out_ready, output out_valid, out_sym, overflow, err_cnt);
endinterface

// File: rtl/seg7_rx_decoder.sv
// seg7_rx_decoder: synchronize, debounce and decode a 7-segment bus into a symbol FIFO (SEG7_ERR_CNT_EN adds an invalid-pattern counter)
module seg7_rx_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input logic              clk,
   input logic              rst_n,
   seg7_rx_decoder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH + 1);
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
   localparam logic [AW-1:0] FULL = AW'(FIFO_DEPTH);
   logic [6:0] sync1_q, sync2_q, cand_q, cand_d, last_q, last_d;
   logic [7:0] cnt_q, cnt_d;
   logic       commit;
   logic [4:0] sym;
   logic [FIFO_DEPTH-1:0][4:0] mem_q, mem_d;
   logic [FIFO_DEPTH-1:0]      vld_q, vld_d;
   logic [AW-1:0] occ_q, occ_d, occ_pop;
   logic ovf_q, ovf_d, pop, push, full;
   assign cand_d = sync2_q != cand_q ? sync2_q : cand_q;
   assign cnt_d  = sync2_q != cand_q ? 8'd1 : (cnt_q < STABLE ? cnt_q + 8'd1 : cnt_q);
   assign commit = cnt_q == STABLE && cand_q != last_q;
   assign last_d = commit ? cand_q : last_q;
   always_comb begin
      sym = 5'd31;
      case (cand_q)
         7'h3F: sym = 5'd0;
         7'h06: sym = 5'd1;
         7'h5B: sym = 5'd2;
         7'h4F: sym = 5'd3;
         7'h66: sym = 5'd4;
         7'h6D: sym = 5'd5;
         7'h7D: sym = 5'd6;
         7'h07: sym = 5'd7;
         7'h7F: sym = 5'd8;
         7'h6F: sym = 5'd9;
         7'h77: sym = 5'd10;
         7'h7C: sym = 5'd11;
         7'h39: sym = 5'd12;
         7'h5E: sym = 5'd13;
         7'h79: sym = 5'd14;
         7'h71: sym = 5'd15;
         7'h00: sym = 5'd16;
         7'h40: sym = 5'd17;
         default: sym = 5'd31;
      endcase
   end
   // Shift-register FIFO: entry 0 is always the head, so out_sym/out_valid are plain flops
   assign full    = occ_q == FULL;
   assign pop     = vld_q[0] && bus.out_ready;
   assign push    = commit && (!full || pop);
   assign occ_pop = occ_q - AW'(pop);
   always_comb begin
      mem_d = pop ? mem_q >> 5 : mem_q;
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (push && AW'(i) == occ_pop) mem_d[i] = sym;
      occ_d = bus.clr ? '0 : occ_pop + AW'(push);
      ovf_d = bus.clr ? 1'b0 : ovf_q | (commit && full && !pop);
      for (int i = 0; i < FIFO_DEPTH; i++)
         vld_d[i] = AW'(i) < occ_d;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
         mem_q   <= '0;
         vld_q   <= '0;
         occ_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         sync1_q <= bus.seg_in;
         sync2_q <= sync1_q;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         mem_q   <= mem_d;
         vld_q   <= vld_d;
         occ_q   <= occ_d;
         ovf_q   <= ovf_d;
      end
   end
   assign bus.out_valid = vld_q[0];
   assign bus.out_sym   = mem_q[0];
   assign bus.overflow  = ovf_q;
`ifdef SEG7_ERR_CNT_EN
   logic [7:0] err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= '0;
      else if (bus.clr)
         err_q <= '0;
      else if (commit && sym == 5'd31 && err_q != 8'hFF)
         err_q <= err_q + 8'd1;
   end
   assign bus.err_cnt = err_q;
`else
   assign bus.err_cnt = '0;
`endif
endmodule

// File: doc/seg7_rx_decoder.md
Name: seg7_rx_decoder

Overview:
- Receive end of the calculator's 7-segment output bus.
- Samples a 7-bit segment pattern, filters glitches with a stability window and decodes the pattern to a symbol code.
- Queues each newly displayed symbol in a small FIFO with a valid/ready interface.
- Used as an on-chip loopback checker and as the decode front end for downstream logging of displayed results.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern is accepted. Legal range 1..255.
- FIFO_DEPTH, 4: symbol queue depth. Power of two, 2..16.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  7  segment pattern; bit0=a … bit6=g; active-high
- clr  input  1  synchronous clear: flushes FIFO, overflow and error state
- out_valid  output  1  FIFO head holds a symbol
- out_ready  input  1  consumer accepts head when high with out_valid
- out_sym  output  5  head symbol: 0–15 = hex digit, 16 = blank, 17 = minus, 31 = invalid pattern
- overflow  output  1  sticky: a symbol was dropped because the FIFO was full
- err_cnt  output  8  invalid-pattern counter (see Optional Feature)

Behaviour:
- Reset: clock is clk, reset is rst_n, asynchronous active-low.
  - Outputs on reset: out_valid=0, out_sym=0, overflow=0, err_cnt=0.
  - Synchronizer and last-accepted register reset to 0x00 (blank).
  - Stability counter resets to 0; FIFO resets to empty.
- Input synchronizer: seg_in passes through a 2-flop synchronizer; s = second-stage value.
- Stability filter: counter cnt and candidate register cand.
  - If s != cand: cand<=s, cnt<=1.
  - Else, if cnt<STABLE_CYCLES: cnt<=cnt+1.
  - When cnt reaches STABLE_CYCLES (held there, saturated): if cand != last, emit one commit pulse and set last<=cand.
  - A pattern held indefinitely commits once only. A glitch shorter than STABLE_CYCLES produces no commit.
  - A return to the last-accepted pattern produces no commit.
- Decode table (pattern -> symbol), combinational on cand:
  - Digits: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9.
  - Letters: 0x77->A, 0x7C->b, 0x39->C, 0x5E->d, 0x79->E, 0x71->F.
  - Other: 0x00->16, 0x40->17, all other patterns->31.
- Latency: seg_in changes at edge N with the FIFO empty and stable thereafter -> out_valid=1 in the cycle after edge N+2+STABLE_CYCLES.
  - 2 cycles for the synchronizer, STABLE_CYCLES for the filter, 1 for the FIFO write.
- FIFO: registered head.
  - out_sym and out_valid come directly from registers and are stable while out_valid=1 and out_ready=0.
  - Pop occurs on a clock edge with out_valid && out_ready.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Commit when full and no pop that cycle: symbol dropped, overflow<=1 (sticky until clr or reset).
  - Commit when full with a simultaneous pop: push accepted, no overflow.
- clr:
  - Empties the FIFO and zeroes overflow and err_cnt.
  - Does not reset the synchronizer, the filter or last, so the displayed pattern is not re-committed.
  - clr has priority over a same-cycle push or pop.
- Reset mid-operation clears everything immediately (asynchronous); the first post-reset non-blank stable pattern commits normally.

Optional Feature:
- Macro: SEG7_ERR_CNT_EN.
- Defined: err_cnt increments, saturating at 255, on every commit whose symbol is 31. This happens even if the symbol is dropped for overflow.
- Undefined: counter logic is absent and err_cnt is tied to 0. The invalid symbol is still queued in both cases.

Test Plan:
- Reset then hold seg_in=0x4F with out_ready=0, STABLE_CYCLES=4 -> out_valid rises exactly 7 cycles after the change, out_sym=3, and it stays valid and unchanged.
- Drive 0x06 for 3 cycles between two long 0x3F intervals -> exactly one symbol (0) is queued; the glitch is not queued.
- Drive 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D (each held 10 cycles) with out_ready=0, FIFO_DEPTH=4 -> FIFO holds 0,1,2,3; overflow=1. Drain with out_ready=1 -> 0,1,2,3 in order, then out_valid=0.
- FIFO full, commit coinciding with out_ready=1 -> no overflow, new symbol appears last.
- Drive 0x12 then 0x40 -> symbols 31 then 17. err_cnt=1 with SEG7_ERR_CNT_EN defined, 0 without. Pulse clr -> err_cnt=0, out_valid=0, overflow=0.
- Assert rst_n=0 mid-stability-window while the FIFO is non-empty -> all outputs return to reset values within the same cycle, with no spurious commit after release.
